// File: rtl/spi_pkg.sv
// Shared types and SPI mode constants for the frame slave.
// No logic here; imported by spi_frame_slave.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    WAIT = 2'd2,
    TX   = 2'd3
  } spi_state_t;

  // CPHA value selecting which sck edge samples data
  localparam logic CPHA_SAMPLE_LEAD  = 1'b0;
  localparam logic CPHA_SAMPLE_TRAIL = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with a parametrised reset value.
// Latency: 2 clk; no backpressure.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/spi_frame_slave.sv
// SPI frame slave: oversampled sck, fixed-length receive frame then a response frame.
// Latency ~3 clk from an sck edge to its effect; tx_data is taken only while tx_ready is high.
module spi_frame_slave
  import spi_pkg::*;
#(
  parameter int RX_WIDTH = 256,
  parameter int TX_WIDTH = 128,
  parameter bit CPOL     = 1'b0,
  parameter bit CPHA     = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_sck,
  input  logic                i_sdi,
  input  logic                i_load,
  output logic                o_sdo,
  output logic [RX_WIDTH-1:0] o_rx_data,
  output logic                o_rx_valid,
  output logic                o_rx_err,
  input  logic [TX_WIDTH-1:0] i_tx_data,
  input  logic                i_tx_valid,
  output logic                o_tx_ready,
  output logic                o_tx_done
);

  localparam int CNT_W = $clog2(max_int(RX_WIDTH, TX_WIDTH) + 1);
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(RX_WIDTH - 1);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TX_WIDTH - 1);
  localparam logic [CNT_W-1:0] TX_FULL = CNT_W'(TX_WIDTH);

  logic w_sck_s, w_sdi_s, w_load_s;
  logic r_sck_d, r_load_d;
  logic w_lead, w_trail, w_sample, w_shift_edge;
  logic w_load_rise, w_load_fall;

  spi_state_t r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [RX_WIDTH-1:0] r_rx_shift, r_rx_data;
  logic [TX_WIDTH-1:0] r_tx_shift;
  logic r_sdo, r_rx_valid, r_rx_err, r_tx_ready, r_tx_done;

  logic w_cnt_clr, w_rx_shift, w_rx_commit, w_rx_err;
  logic w_tx_load, w_tx_adv, w_tx_done, w_tx_present_msb;

  sync2 #(.RST_VAL(CPOL)) u_sync_sck  (.i_clk(i_clk), .i_reset(i_reset), .i_d(i_sck),  .o_q(w_sck_s));
  sync2 #(.RST_VAL(1'b0)) u_sync_sdi  (.i_clk(i_clk), .i_reset(i_reset), .i_d(i_sdi),  .o_q(w_sdi_s));
  sync2 #(.RST_VAL(1'b0)) u_sync_load (.i_clk(i_clk), .i_reset(i_reset), .i_d(i_load), .o_q(w_load_s));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sck_d  <= CPOL;
      r_load_d <= 1'b0;
    end else begin
      r_sck_d  <= w_sck_s;
      r_load_d <= w_load_s;
    end
  end

  // Leading edge leaves the idle level, trailing edge returns to it
  assign w_lead       = (w_sck_s != r_sck_d) && (w_sck_s != CPOL);
  assign w_trail      = (w_sck_s != r_sck_d) && (w_sck_s == CPOL);
  assign w_sample     = (CPHA == CPHA_SAMPLE_LEAD) ? w_lead  : w_trail;
  assign w_shift_edge = (CPHA == CPHA_SAMPLE_LEAD) ? w_trail : w_lead;
  assign w_load_rise  = w_load_s & ~r_load_d;
  assign w_load_fall  = ~w_load_s & r_load_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_rx_shift  = 1'b0;
    w_rx_commit = 1'b0;
    w_rx_err    = 1'b0;
    w_tx_load   = 1'b0;
    w_tx_adv    = 1'b0;
    w_tx_done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_load_rise) begin
          w_state_nxt = RX;
          w_cnt_clr   = 1'b1;
          w_rx_shift  = w_sample;
        end
      end
      RX: begin
        if (w_sample && (r_cnt == RX_LAST)) begin
          w_rx_shift  = 1'b1;
          w_rx_commit = 1'b1;
          w_state_nxt = WAIT;
        end else if (w_load_fall) begin
          w_rx_err    = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_sample) begin
          w_rx_shift  = 1'b1;
        end
      end
      WAIT: begin
        if (i_tx_valid && !w_load_s) begin
          w_tx_load   = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = TX;
        end
      end
      TX: begin
        if (w_load_rise) begin
          w_state_nxt = RX;
          w_cnt_clr   = 1'b1;
          w_rx_shift  = w_sample;
        end else if (CPHA == CPHA_SAMPLE_LEAD) begin
          if (w_shift_edge) begin
            if (r_cnt == TX_LAST) begin
              w_tx_done   = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_tx_adv = 1'b1;
            end
          end
        end else begin
          // Finish on the trailing edge that samples the last bit, not on its leading edge
          if (w_lead && (r_cnt != TX_FULL)) begin
            w_tx_adv = 1'b1;
          end else if (w_trail && (r_cnt == TX_FULL)) begin
            w_tx_done   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_tx_present_msb = (CPHA == CPHA_SAMPLE_TRAIL) && (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt      <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_tx_shift <= '0;
      r_sdo      <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      r_tx_ready <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      if (w_cnt_clr)                  r_cnt <= w_rx_shift ? CNT_W'(1) : '0;
      else if (w_rx_shift || w_tx_adv) r_cnt <= r_cnt + CNT_W'(1);

      if (w_rx_shift)  r_rx_shift <= {r_rx_shift[RX_WIDTH-2:0], w_sdi_s};
      if (w_rx_commit) r_rx_data  <= {r_rx_shift[RX_WIDTH-2:0], w_sdi_s};

      if (w_tx_load)
        r_tx_shift <= i_tx_data;
      else if (w_tx_adv && !w_tx_present_msb)
        r_tx_shift <= {r_tx_shift[TX_WIDTH-2:0], 1'b0};

      if (w_state_nxt != TX)
        r_sdo <= 1'b0;
      else if (w_tx_load)
        r_sdo <= (CPHA == CPHA_SAMPLE_LEAD) ? i_tx_data[TX_WIDTH-1] : 1'b0;
      else if (w_tx_adv)
        r_sdo <= w_tx_present_msb ? r_tx_shift[TX_WIDTH-1] : r_tx_shift[TX_WIDTH-2];

      r_rx_valid <= w_rx_commit;
      r_rx_err   <= w_rx_err;
      r_tx_done  <= w_tx_done;
      r_tx_ready <= (w_state_nxt == WAIT);
    end
  end

  assign o_sdo      = r_sdo;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_rx_err   = r_rx_err;
  assign o_tx_ready = r_tx_ready;
  assign o_tx_done  = r_tx_done;

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench: mode-0 default instance and a mode-3 narrow instance driven as an SPI master.
module tb_spi_frame_slave;

  localparam logic [127:0] TXW = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [255:0] P_A5 = {32{8'hA5}};
  localparam logic [255:0] P1   = {32{8'h3C}};
  localparam logic [255:0] P2   = {16{16'h1234}};
  localparam logic [255:0] P3   = {8{32'hDEADBEEF}};
  localparam logic [255:0] P_FF = {32{8'hFF}};

  logic clk = 1'b0;
  logic reset;

  logic sck_a, sdi_a, load_a, sdo_a, rx_valid_a, rx_err_a, tx_valid_a, tx_ready_a, tx_done_a;
  logic [255:0] rx_data_a;
  logic [127:0] tx_data_a;

  logic sck_b, sdi_b, load_b, sdo_b, rx_valid_b, rx_err_b, tx_valid_b, tx_ready_b, tx_done_b;
  logic [15:0] rx_data_b;
  logic [7:0]  tx_data_b;

  logic so_a, so_b;
  logic [127:0] got_a;
  logic [7:0]   got_b;

  int total = 0;
  int bad   = 0;
  int n_rxv_a = 0, n_err_a = 0, n_done_a = 0, n_rxv_b = 0, n_done_b = 0;

  spi_frame_slave u_dut_a (
    .i_clk(clk), .i_reset(reset), .i_sck(sck_a), .i_sdi(sdi_a), .i_load(load_a),
    .o_sdo(sdo_a), .o_rx_data(rx_data_a), .o_rx_valid(rx_valid_a), .o_rx_err(rx_err_a),
    .i_tx_data(tx_data_a), .i_tx_valid(tx_valid_a), .o_tx_ready(tx_ready_a), .o_tx_done(tx_done_a)
  );

  spi_frame_slave #(.RX_WIDTH(16), .TX_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1)) u_dut_b (
    .i_clk(clk), .i_reset(reset), .i_sck(sck_b), .i_sdi(sdi_b), .i_load(load_b),
    .o_sdo(sdo_b), .o_rx_data(rx_data_b), .o_rx_valid(rx_valid_b), .o_rx_err(rx_err_b),
    .i_tx_data(tx_data_b), .i_tx_valid(tx_valid_b), .o_tx_ready(tx_ready_b), .o_tx_done(tx_done_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid_a) n_rxv_a++;
    if (rx_err_a)   n_err_a++;
    if (tx_done_a)  n_done_a++;
    if (rx_valid_b) n_rxv_b++;
    if (tx_done_b)  n_done_b++;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mode 0 master: data set while sck low, slave samples on the rising edge
  task automatic a_bit(input logic d);
    sdi_a = d;
    wait_clk(5);
    so_a  = sdo_a;
    sck_a = 1'b1;
    wait_clk(5);
    sck_a = 1'b0;
  endtask

  task automatic a_rx(input logic [255:0] pat, input int nbits);
    for (int i = 0; i < nbits; i++) a_bit(pat[255-i]);
    wait_clk(5);
  endtask

  task automatic a_tx(input int nbits);
    got_a = '0;
    for (int i = 0; i < nbits; i++) begin
      a_bit(1'b0);
      got_a = {got_a[126:0], so_a};
    end
    wait_clk(5);
  endtask

  task automatic a_offer_tx();
    tx_data_a  = TXW;
    tx_valid_a = 1'b1;
    wait_clk(10);
    tx_valid_a = 1'b0;
    wait_clk(5);
  endtask

  // mode 3 master: data changes on the falling (leading) edge, sampled on the rising edge
  task automatic b_bit(input logic d);
    sdi_b = d;
    sck_b = 1'b0;
    wait_clk(5);
    so_b  = sdo_b;
    sck_b = 1'b1;
    wait_clk(5);
  endtask

  initial begin
    reset = 1'b1;
    sck_a = 1'b0; sdi_a = 1'b0; load_a = 1'b0; tx_data_a = '0; tx_valid_a = 1'b0;
    sck_b = 1'b1; sdi_b = 1'b0; load_b = 1'b0; tx_data_b = '0; tx_valid_b = 1'b0;
    so_a = 1'b0; so_b = 1'b0; got_a = '0; got_b = '0;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(3);

    chk("rst_rx_data_a", rx_data_a, 256'd0);
    chk("rst_flags_a", 256'({sdo_a, rx_valid_a, rx_err_a, tx_ready_a, tx_done_a}), 256'd0);
    chk("rst_flags_b", 256'({rx_data_b, sdo_b, tx_ready_b, tx_done_b}), 256'd0);

    // full receive frame
    load_a = 1'b1;
    wait_clk(5);
    a_rx(P_A5, 256);
    chk("rx_a5_data", rx_data_a, P_A5);
    chk("rx_a5_valid_cnt", 256'(n_rxv_a), 256'd1);
    chk("wait_tx_ready", 256'(tx_ready_a), 256'd1);
    chk("wait_sdo", 256'(sdo_a), 256'd0);

    // response frame
    load_a = 1'b0;
    a_offer_tx();
    chk("tx_ready_in_tx", 256'(tx_ready_a), 256'd0);
    a_tx(128);
    chk("tx_stream", 256'(got_a), 256'(TXW));
    chk("tx_done_cnt", 256'(n_done_a), 256'd1);
    chk("tx_idle_sdo_rdy", 256'({sdo_a, tx_ready_a}), 256'd0);

    // tx_valid outside WAIT is ignored
    tx_valid_a = 1'b1;
    wait_clk(5);
    chk("idle_tx_ready", 256'(tx_ready_a), 256'd0);
    tx_valid_a = 1'b0;

    // short frame
    load_a = 1'b1;
    wait_clk(5);
    a_rx(P_FF, 100);
    load_a = 1'b0;
    wait_clk(10);
    chk("short_err_cnt", 256'(n_err_a), 256'd1);
    chk("short_valid_cnt", 256'(n_rxv_a), 256'd1);
    chk("short_data_hold", rx_data_a, P_A5);

    // tx aborted by a new load rising edge
    load_a = 1'b1;
    wait_clk(5);
    a_rx(P1, 256);
    chk("rx_p1", rx_data_a, P1);
    load_a = 1'b0;
    a_offer_tx();
    a_tx(40);
    chk("abort_first40", 256'(got_a[39:0]), 256'(TXW[127:88]));
    load_a = 1'b1;
    wait_clk(10);
    chk("abort_no_done", 256'(n_done_a), 256'd1);
    chk("abort_sdo", 256'(sdo_a), 256'd0);
    a_rx(P2, 256);
    chk("rx_after_abort", rx_data_a, P2);
    chk("rx_after_abort_cnt", 256'(n_rxv_a), 256'd3);

    // another full response, then reset in the middle of a receive frame
    load_a = 1'b0;
    a_offer_tx();
    a_tx(128);
    chk("tx_stream_2", 256'(got_a), 256'(TXW));
    chk("tx_done_cnt_2", 256'(n_done_a), 256'd2);
    load_a = 1'b1;
    wait_clk(5);
    a_rx(P3, 50);
    reset = 1'b1;
    wait_clk(1);
    chk("midrx_reset_data", rx_data_a, 256'd0);
    chk("midrx_reset_flags", 256'({sdo_a, rx_valid_a, rx_err_a, tx_ready_a, tx_done_a}), 256'd0);
    load_a = 1'b0;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(5);
    chk("midrx_no_pulses", 256'({n_err_a, n_rxv_a}), 256'({32'd1, 32'd3}));
    load_a = 1'b1;
    wait_clk(5);
    a_rx(P3, 256);
    chk("rx_after_reset", rx_data_a, P3);
    chk("rx_after_reset_cnt", 256'(n_rxv_a), 256'd4);

    // mode 3, narrow frames
    load_b = 1'b1;
    wait_clk(5);
    for (int i = 0; i < 16; i++) begin
      logic [15:0] pat;
      pat = 16'hBEEF;
      b_bit(pat[15-i]);
    end
    wait_clk(5);
    chk("b_rx_data", 256'(rx_data_b), 256'(16'hBEEF));
    chk("b_rx_valid_cnt", 256'(n_rxv_b), 256'd1);
    chk("b_tx_ready", 256'(tx_ready_b), 256'd1);
    load_b = 1'b0;
    tx_data_b  = 8'h3C;
    tx_valid_b = 1'b1;
    wait_clk(10);
    tx_valid_b = 1'b0;
    wait_clk(5);
    chk("b_sdo_before_lead", 256'(sdo_b), 256'd0);
    for (int i = 0; i < 8; i++) begin
      b_bit(1'b0);
      got_b = {got_b[6:0], so_b};
    end
    wait_clk(10);
    chk("b_tx_bits", 256'(got_b), 256'(8'h3C));
    chk("b_tx_done_cnt", 256'(n_done_b), 256'd1);
    chk("b_idle_sdo_rdy", 256'({sdo_b, tx_ready_b}), 256'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_frame_slave.md
SPI_FRAME_SLAVE -- requirements
Module: spi_frame_slave

Interface
REQ-001 Parameter RX_WIDTH, default 256, bits per receive frame (>=8).
REQ-002 Parameter TX_WIDTH, default 128, bits per transmit frame (>=8).
REQ-003 Parameter CPOL, default 0, sck idle level.
REQ-004 Parameter CPHA, default 0; 0 = sample on leading edge and shift on trailing edge, 1 = shift on leading edge and sample on trailing edge.
REQ-005 clk  input  1  system clock; the only clock in the block; sck is sampled as data and never used as a clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 sck  input  1  SPI serial clock, asynchronous to clk.
REQ-008 sdi  input  1  SPI serial data in, MSB first.
REQ-009 load  input  1  frame qualifier; high = receive phase, low = transmit phase; asynchronous.
REQ-010 sdo  output  1  SPI serial data out, MSB first.
REQ-011 rx_data  output  RX_WIDTH  last complete received frame.
REQ-012 rx_valid  output  1  one-clk pulse when rx_data updates.
REQ-013 rx_err  output  1  one-clk pulse on a short frame.
REQ-014 tx_data  input  TX_WIDTH  response word from the core.
REQ-015 tx_valid  input  1  core asserts when tx_data is valid (core "done").
REQ-016 tx_ready  output  1  high while the block can accept tx_data.
REQ-017 tx_done  output  1  one-clk pulse after the last tx bit is shifted.

Function
REQ-018 sck, sdi and load SHALL each pass through a 2-FF synchronizer; sck edges SHALL be detected on the synchronized signal; supported sck frequency is <= clk/8.
REQ-019 The FSM SHALL have the states IDLE, RX, WAIT and TX.
REQ-020 IDLE: on a rising edge of synchronized load -> RX; clear the bit counter.
REQ-021 RX: on each sample edge, shift synchronized sdi into rx_shift at the LSB (first bit ends at the MSB) and increment the counter.
REQ-022 RX: on sample edge number RX_WIDTH, rx_data <= rx_shift (including the final bit), rx_valid = 1 for one cycle on the following clk, -> WAIT.
REQ-023 RX: if load falls before RX_WIDTH bits, pulse rx_err, keep rx_data unchanged, -> IDLE.
REQ-024 WAIT: tx_ready = 1; ignore sck edges; when tx_valid = 1 and synchronized load = 0, capture tx_data into tx_shift, clear the counter, -> TX.
REQ-025 TX with CPHA=0: drive sdo = tx_data MSB in the capture cycle; advance one bit on each trailing edge.
REQ-026 TX with CPHA=1: drive sdo = MSB on the first leading edge; advance one bit on each later leading edge.
REQ-027 TX: after TX_WIDTH bits have been presented and the last shift edge has occurred, pulse tx_done, -> IDLE.
REQ-028 TX: a rising edge of load SHALL abort TX, without tx_done, and enter RX with the counter cleared.
REQ-029 sdo SHALL be 0 in IDLE, RX and WAIT.
REQ-030 tx_ready SHALL be 0 outside WAIT; tx_valid outside WAIT is ignored and not queued.
REQ-031 The counter SHALL be $clog2(max(RX_WIDTH,TX_WIDTH)+1) bits wide and SHALL never wrap within a frame.
REQ-032 If load rises and a sample edge is detected in the same clk, the edge SHALL count as bit 0 of the frame.

Reset
REQ-033 On reset, the state SHALL be IDLE and the counter, rx_shift, tx_shift, rx_data, sdo, rx_valid, rx_err, tx_ready and tx_done SHALL all be 0.
REQ-034 On reset, the synchronizer flops SHALL load CPOL for sck and 0 for sdi and load, so reset creates no spurious edge.
REQ-035 Reset mid-frame SHALL discard the partial frame with no pulse outputs.

Structure
REQ-036 A shared package spi_pkg SHALL hold the state enum spi_state_t and the mode constants (CPOL/CPHA edge selection).
REQ-037 A single sub-module sync2 (2-FF synchronizer, parametrised reset value) SHALL be instantiated three times; the FSM and shifters stay in spi_frame_slave.

Verification
REQ-038 Defaults, mode 0, sck = clk/10: load high, 256 bits of 0xA5 pattern -> rx_data = {32{8'hA5}}, one rx_valid pulse, tx_ready high.
REQ-039 Then load low, tx_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 with tx_valid, 128 sck -> sdo stream matches MSB-first, one tx_done, state IDLE.
REQ-040 CPHA=1, CPOL=1, RX_WIDTH=16, TX_WIDTH=8: rx 16'hBEEF, tx 8'h3C -> rx_data = 16'hBEEF, sdo bits 0,0,1,1,1,1,0,0 on the leading edges.
REQ-041 Load drops after 100 of 256 bits -> one rx_err pulse, rx_data holds its previous value, no rx_valid.
REQ-042 Load rises after 40 of 128 tx bits -> no tx_done; a following 256-bit frame is received correctly.
REQ-043 Reset asserted mid-RX at bit 50 -> all outputs 0 next clk; the next full frame is received correctly.
